lsu_mem_master: RTL and testbench

- Load/store initiator for miniRV; sits between the core's execute stage and the `mem` data port.
- Accepts one load/store request at a time and drives `mem_addr`, `mem_wen`, `mem_wdata` and `mem_wstrb`.
- Samples the combinational `mem_rdata` and returns the byte/half/word result, sign- or zero-extended, in a registered response.

---
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_mem_master.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - request/response and memory-port bundle for lsu_mem_master
// master = the load/store unit's view, slave = the core/memory environment's view.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wen, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wen, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - miniRV load/store initiator, one request per IDLE->ACCESS->RESP pass
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into rsp_err.
module lsu_mem_master #(
  parameter int ADDR_W          = 32,
  parameter bit WORD_ALIGN_ADDR = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  lsu_mem_master_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              ready_c, rsp_valid_c, mem_wen_c;
  logic              illegal, misalign, req_err;
  logic [1:0]        req_off;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_wstrb;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_data;

  // Request decode: error flag, lane offset and store formatting.
  always_comb begin
    illegal = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                         : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110);
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_funct3[1:0])
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`endif
    req_err = illegal | misalign;
    // Half/word lanes always use the forced-aligned offset.
    case (bus.req_funct3[1:0])
      2'b00:   req_off = bus.req_addr[1:0];
      2'b01:   req_off = {bus.req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
    case (bus.req_funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{bus.req_wdata[7:0]}};
        fmt_wstrb = 4'b0001 << req_off;
      end
      2'b01: begin
        fmt_wdata = {2{bus.req_wdata[15:0]}};
        fmt_wstrb = 4'b0011 << req_off;
      end
      default: begin
        fmt_wdata = bus.req_wdata;
        fmt_wstrb = 4'b1111;
      end
    endcase
    if (!bus.req_we || req_err) fmt_wstrb = 4'b0000;
  end

  always_comb begin
    rd_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = bus.mem_rdata;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = 32'd0;
    endcase
    if (we_q || err_q) ld_data = 32'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    rsp_valid_c = 1'b0;
    mem_wen_c   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_wen_c = we_q & ~err_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = ready_c & bus.req_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q        <= bus.req_we;
        funct3_q    <= bus.req_funct3;
        off_q       <= req_off;
        err_q       <= req_err;
        mem_addr_q  <= WORD_ALIGN_ADDR ? {bus.req_addr[ADDR_W-1:2], 2'b00} : bus.req_addr;
        mem_wdata_q <= fmt_wdata;
        mem_wstrb_q <= fmt_wstrb;
      end
      if (state_q == ACCESS) begin
        rsp_rdata_q <= ld_data;
        rsp_err_q   <= err_q;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wen   = mem_wen_c;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - randomized and directed bench for lsu_mem_master
// Checks against a transaction-level model; honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_W(32)) bus ();

  lsu_mem_master #(.ADDR_W(32), .WORD_ALIGN_ADDR(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic m_err(req_t r);
    logic bad;
    bad = r.we ? (r.f3 > 3'd2) : !(r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    if (r.f3[1:0] == 2'd1 && (r.addr % 2) != 0) bad = 1'b1;
    if (r.f3[1:0] == 2'd2 && (r.addr % 4) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int m_off(req_t r);
    case (r.f3[1:0])
      2'd0:    return int'(r.addr % 4);
      2'd1:    return int'((r.addr % 4) / 2) * 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(req_t r);
    case (r.f3[1:0])
      2'd0:    return {24'd0, r.wdata[7:0]} * 32'h01010101;
      2'd1:    return {16'd0, r.wdata[15:0]} * 32'h00010001;
      default: return r.wdata;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(req_t r);
    if (!r.we) return 4'd0;
    case (r.f3[1:0])
      2'd0:    return 4'(1 << m_off(r));
      2'd1:    return 4'(3 << m_off(r));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_load(req_t r, logic [31:0] rd);
    logic [31:0] b, h;
    if (r.we || m_err(r)) return 32'd0;
    b = (rd >> (8 * m_off(r))) & 32'hFF;
    h = (rd >> (8 * m_off(r))) & 32'hFFFF;
    case (r.f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    return rd;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction model: phase 0 idle, 1 memory access, 2 response.
  int          phase;
  req_t        cur;
  logic [31:0] e_addr, e_rdata;
  logic        e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 0;
      e_addr  <= 32'd0;
      e_rdata <= 32'd0;
      e_err   <= 1'b0;
    end else begin
      case (phase)
        0: if (bus.req_valid) begin
          cur.we    <= bus.req_we;
          cur.f3    <= bus.req_funct3;
          cur.addr  <= bus.req_addr;
          cur.wdata <= bus.req_wdata;
          e_addr    <= bus.req_addr & ~32'h3;
          phase     <= 1;
        end
        1: begin
          e_rdata <= m_load(cur, bus.mem_rdata);
          e_err   <= m_err(cur);
          phase   <= 2;
        end
        default: phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", bus.req_ready, phase == 0);
      chk("rsp_valid", bus.rsp_valid, phase == 2);
      chk("mem_wen", bus.mem_wen, phase == 1 && cur.we && !m_err(cur));
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("rsp_rdata", bus.rsp_rdata, e_rdata);
      chk("rsp_err", bus.rsp_err, e_err);
      if (phase == 1 && !(cur.we && m_err(cur))) chk("mem_wstrb", bus.mem_wstrb, m_wstrb(cur));
      if (phase == 1 && cur.we && !m_err(cur)) chk("mem_wdata", bus.mem_wdata, m_wdata(cur));
    end
  end

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_rdata  = rdata;
  endtask

  // Issue one request from an idle DUT and collect what it produced.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         output logic [31:0] r_rdata, output logic r_err,
                         output logic [3:0] wstrb, output logic [31:0] wd,
                         output logic [31:0] maddr, output int wen_n);
    logic got;
    got = 1'b0; wen_n = 0; r_rdata = 'x; r_err = 1'bx; wstrb = 'x; wd = 'x; maddr = 'x;
    drive(we, f3, addr, wdata, rdata);
    bus.req_valid = 1'b1;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_wen) begin
        wen_n++; wstrb = bus.mem_wstrb; wd = bus.mem_wdata; maddr = bus.mem_addr;
      end
      if (bus.rsp_valid) begin
        got = 1'b1; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  logic [31:0] rr, wd, ma;
  logic        re;
  logic [3:0]  ws;
  int          wn, n_rdy, n_rsp;

  initial begin
    bus.req_valid = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0);
    #12;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;

    run_req(1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0, rr, re, ws, wd, ma, wn);
    chk("sb_wstrb", ws, 4'b1000);
    chk("sb_wdata", wd, 32'hA5A5A5A5);
    chk("sb_addr", ma, 32'h80000000);
    chk("sb_wen_cycles", wn, 1);
    chk("sb_rdata", rr, 0);
    run_req(1'b0, 3'b000, 32'h80000003, 32'h0, 32'hA5000000, rr, re, ws, wd, ma, wn);
    chk("lb_rdata", rr, 32'hFFFFFFA5);
    chk("lb_wen_cycles", wn, 0);
    run_req(1'b0, 3'b100, 32'h80000003, 32'h0, 32'hA5000000, rr, re, ws, wd, ma, wn);
    chk("lbu_rdata", rr, 32'h000000A5);
    run_req(1'b1, 3'b001, 32'h80000002, 32'h00008001, 32'h0, rr, re, ws, wd, ma, wn);
    chk("sh_wstrb", ws, 4'b1100);
    chk("sh_wdata", wd, 32'h80018001);
    run_req(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80010000, rr, re, ws, wd, ma, wn);
    chk("lh_rdata", rr, 32'hFFFF8001);
    run_req(1'b1, 3'b100, 32'h80000004, 32'hDEADBEEF, 32'h0, rr, re, ws, wd, ma, wn);
    chk("ill_wen_cycles", wn, 0);
    chk("ill_err", re, 1);
    chk("ill_rdata", rr, 0);
    run_req(1'b0, 3'b010, 32'h80000001, 32'h0, 32'h12345678, rr, re, ws, wd, ma, wn);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lw_err", re, 1);
    chk("mis_lw_rdata", rr, 0);
`else
    chk("mis_lw_err", re, 0);
    chk("mis_lw_rdata", rr, 32'h12345678);
`endif

    // Back-to-back: req_valid held high.
    drive(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h11223344);
    bus.req_valid = 1'b1;
    n_rdy = 0; n_rsp = 0;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req_ready) n_rdy++;
      if (bus.rsp_valid) begin
        n_rsp++;
        chk("b2b_rdata", bus.rsp_rdata, 32'h11223344);
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_rsp_count", n_rsp, 4);
    chk("b2b_ready_count", n_rdy, 4);
    @(posedge clk); #2;

    // Reset in the middle of a word store.
    drive(1'b1, 3'b010, 32'h80000000, 32'hCAFEF00D, 32'h0);
    bus.req_valid = 1'b1;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("sw_wen_before_rst", bus.mem_wen, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_mem_wen", bus.mem_wen, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_mem_wdata", bus.mem_wdata, 0);
    chk("midrst_mem_wstrb", bus.mem_wstrb, 0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 0);
    chk("midrst_rsp_err", bus.rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_rsp++;
    end
    chk("no_rsp_after_reset", n_rsp, 0);
    @(posedge clk); #2;

    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom_range(0, 1) == 1);
      drive(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
            32'h80000000 | 32'($urandom_range(0, 63)), $urandom, $urandom);
      @(posedge clk); #2;
    end
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
